// File: rtl/frame_buffer_writer.sv
// Write engine that packs an RGB pixel stream into 32-bit words and fills the
// Buf0/Buf1 ping-pong line buffers in strict alternation, one frame per buffer.
module frame_buffer_writer #(
    parameter int ADDR_W = 20,
    parameter int CNT_W  = 10,
    parameter int IDX_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Enable,
    input  logic [CNT_W-1:0]  AIPOut,
    input  logic [CNT_W-1:0]  AILOut,
    input  logic              PxValid,
    input  logic [7:0]        PxR,
    input  logic [7:0]        PxG,
    input  logic [7:0]        PxB,
    output logic              PxReady,
    input  logic              Buf0Empty,
    input  logic              Buf1Empty,
    output logic [31:0]       WData,
    output logic [ADDR_W-1:0] WAddr,
    output logic              WE0,
    output logic              WE1,
    output logic              CSDisplay,
    output logic              FrameDone,
    output logic [IDX_W-1:0]  FrameWInd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUF,
        S_FILL,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              cur_buf_q, cur_buf_d;
    logic [CNT_W-1:0]  aip_q, aip_d;
    logic [CNT_W-1:0]  ail_q, ail_d;
    logic [CNT_W-1:0]  px_q, px_d;
    logic [CNT_W-1:0]  line_q, line_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we0_q, we0_d;
    logic              we1_q, we1_d;

    logic              target_empty;
    logic              sizes_ok;
    logic              accept;
    logic              end_of_line;
    logic              last_line;

    always_comb begin
        // Only the buffer whose turn it is matters; the other flag is ignored.
        target_empty = cur_buf_q ? Buf1Empty : Buf0Empty;
        sizes_ok     = (AIPOut != '0) && (AILOut != '0);
        accept       = (state_q == S_FILL) && PxValid;
        end_of_line  = (px_q == aip_q - CNT_W'(1));
        last_line    = (line_q == ail_q - CNT_W'(1));

        state_d   = state_q;
        cur_buf_d = cur_buf_q;
        aip_d     = aip_q;
        ail_d     = ail_q;
        px_d      = px_q;
        line_d    = line_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        we0_d     = 1'b0;
        we1_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Enable) begin
                    state_d = S_WAIT_BUF;
                end
            end
            S_WAIT_BUF: begin
                if (Enable && target_empty && sizes_ok) begin
                    aip_d   = AIPOut;
                    ail_d   = AILOut;
                    addr_d  = '0;
                    px_d    = '0;
                    line_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (accept) begin
                    wdata_d = {8'h00, PxR, PxG, PxB};
                    waddr_d = addr_q;
                    we0_d   = ~cur_buf_q;
                    we1_d   = cur_buf_q;
                    addr_d  = addr_q + ADDR_W'(1);
                    if (end_of_line) begin
                        px_d   = '0;
                        line_d = line_q + CNT_W'(1);
                        if (last_line) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        px_d = px_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                idx_d     = idx_q + IDX_W'(1);
                cur_buf_d = ~cur_buf_q;
                state_d   = Enable ? S_WAIT_BUF : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cur_buf_q <= 1'b0;
            aip_q     <= '0;
            ail_q     <= '0;
            px_q      <= '0;
            line_q    <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            waddr_q   <= '0;
            we0_q     <= 1'b0;
            we1_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_buf_q <= cur_buf_d;
            aip_q     <= aip_d;
            ail_q     <= ail_d;
            px_q      <= px_d;
            line_q    <= line_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            waddr_q   <= waddr_d;
            we0_q     <= we0_d;
            we1_q     <= we1_d;
        end
    end

    // Handshake and status are pure state decodes so PxReady has no input path.
    assign PxReady   = (state_q == S_FILL);
    assign CSDisplay = (state_q == S_FILL);
    assign FrameDone = (state_q == S_DONE);
    assign FrameWInd = idx_q;
    assign WData     = wdata_q;
    assign WAddr     = waddr_q;
    assign WE0       = we0_q;
    assign WE1       = we1_q;

endmodule
